register_file_scoreboard: RTL and testbench
===========================================

# register_file_scoreboard

Parametrised multi-port integer register file with per-register busy scoreboard, same-cycle write-to-read bypass and a sticky protocol-error flag. It sits in the register stage of the pipeline. It replaces the fixed 2-read/1-write register file for dual-issue and variable-width configurations. Decode drives read addresses and an issue request; writeback drives the write ports.

## Interface
Parameters:
- REGISTER_COUNT, 32, number of architectural registers (power of two, ≥ 2); register 0 hard-wired to zero
- WIDTH, `BIT_COUNT, data width in bits
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 1, number of write ports (1..2)
- BYPASS, 1, 1 = a write in cycle N is visible on the read ports in cycle N; 0 = visible from cycle N+1

Ports (AW = $clog2(REGISTER_COUNT)):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- WriteEnable  in  WRITE_PORTS  per-port write strobe
- WriteAdr  in  WRITE_PORTS×AW  per-port destination register
- WriteData  in  WRITE_PORTS×WIDTH  per-port write data
- ReadAdr  in  READ_PORTS×AW  per-port source register
- ReadUse  in  READ_PORTS  port operand is needed by the issuing instruction
- ReadData  out  READ_PORTS×WIDTH  per-port operand value
- ReadReady  out  READ_PORTS  operand value is valid (not pending)
- IssueValid  in  1  decode requests issue of an instruction
- IssueWrites  in  1  issuing instruction writes a register
- IssueRd  in  AW  its destination register
- IssueAccept  out  1  issue allowed this cycle; issue takes effect only when IssueValid && IssueAccept
- Busy  out  REGISTER_COUNT  scoreboard state, bit 0 always 0
- Error  out  1  sticky protocol-error flag

## Operation
- Storage: registers 1..REGISTER_COUNT-1 hold WIDTH bits. Register 0 reads as 0, ignores writes and is never busy.
- Write: on each edge, for each port p with WriteEnable[p] and WriteAdr[p] ≠ 0, store WriteData[p]. If both ports target the same register, the higher port index wins and Error is set.
- Read: ReadData[r] = stored value of ReadAdr[r]. With BYPASS=1, a same-cycle write to ReadAdr[r] (≠ 0) is forwarded; the higher write port wins.
- Clearing: Clearing[i] = some write port targets register i this cycle.
- ReadReady[r] = !Busy[ReadAdr[r]], or (BYPASS=1 and Clearing[ReadAdr[r]]).
- IssueAccept = every port with ReadUse set has ReadReady, and, if IssueWrites, (!Busy[IssueRd] || Clearing[IssueRd]). This blocks RAW and WAW hazards.
- Scoreboard update per edge, in order:
  - clear Busy[i] for every i in Clearing
  - then, on accepted issue with IssueWrites and IssueRd ≠ 0, set Busy[IssueRd]
  - a simultaneous clear and set on the same register leaves it busy
- Error is set on a write-port collision or on a write to a nonzero register whose Busy bit is 0. It is cleared only by reset.

## Timing
- Reset asserted (reset = 0): all registers 0, Busy all 0, Error 0, immediately and asynchronously. ReadData = 0, ReadReady = all 1, IssueAccept = 1.
- Read latency: combinational, 0 cycles. Write latency: 1 cycle to storage.
- Bypass latency: 0 cycles when BYPASS=1.
- A register issued in cycle N reads as not-ready from cycle N+1.
- Reset deasserted mid-operation: no pending writes survive; state starts clean on the first edge after release.
- No combinational path from IssueValid to IssueAccept.

## Structure
- Shared package regfile_pkg: AW localparam function, port-count limits, and an error-cause enum (collision, unexpected write) for bench reporting.
- Storage reuses the existing flopRE per register, and the existing mux for each read port.
- One natural sub-module: regfile_scoreboard, holding the Busy vector, clear/set logic and Error.

## Test plan
- Reset with reset = 0 mid-stream, after r5 is loaded with 0xDEADBEEF and r5 is busy → ReadData of r5 = 0, Busy = 0, Error = 0, IssueAccept = 1.
- Issue IssueRd = 3 at cycle 0; at cycle 2, ReadAdr[0] = 3 with ReadUse → ReadReady[0] = 0 and IssueAccept = 0. Write 0x1234 to r3 at cycle 4 → with BYPASS=1, ReadData[0] = 0x1234 and IssueAccept = 1 in cycle 4; with BYPASS=0, both in cycle 5.
- Write 0xFFFF to r0, then read r0 → returns 0, Busy[0] = 0, Error = 0.
- WRITE_PORTS = 2, both ports write r7 with 0xAA and 0xBB in one cycle → r7 = 0xBB, Error = 1 and stays 1 until reset.
- Same-cycle writeback of r9 and issue of a new writer to r9 → IssueAccept = 1, Busy[9] = 1 next cycle, r9 holds the written value.
- Write to non-busy r4 → Error = 1; READ_PORTS = 4 with all ports reading r4 → identical ReadData on every port.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: address-width helper,
// supported port-count limits and the classification of protocol errors.
package regfile_pkg;

   localparam int MAX_READ_PORTS  = 4;
   localparam int MAX_WRITE_PORTS = 2;

   // Why the sticky Error flag was raised; collision outranks an unexpected write.
   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_COLLISION  = 2'd1,
      ERR_UNEXPECTED = 2'd2
   } err_cause_e;

   // Register-address width for a register count (count is a power of two >= 2).
   function automatic int addr_width(input int count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file: one busy bit per register, cleared
// by writeback and set by an accepted issue, plus the sticky protocol-error flag.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REGISTER_COUNT = 32
)(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [REGISTER_COUNT-1:0]             clearing,
   input  logic                                  collision,
   input  logic                                  issue_set,
   input  logic [addr_width(REGISTER_COUNT)-1:0] issue_rd,
   output logic [REGISTER_COUNT-1:0]             busy,
   output logic                                  error
);

   logic [REGISTER_COUNT-1:0] busy_q;
   logic [REGISTER_COUNT-1:0] busy_nxt;
   logic                      error_q;
   err_cause_e                cause;

   // Classify this cycle's writeback: a port collision, or a write to an idle register
   always_comb begin
      cause = ERR_NONE;
      if (collision) begin
         cause = ERR_COLLISION;
      end else if (|(clearing & ~busy_q)) begin
         cause = ERR_UNEXPECTED;
      end
   end

   // Clears apply first and the accepted issue sets afterwards, so clear+set on one register leaves it busy
   always_comb begin
      busy_nxt = busy_q & ~clearing;
      if (issue_set) begin
         busy_nxt[issue_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard and sticky error state; only reset clears the error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= '0;
         error_q <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         if (cause != ERR_NONE) begin
            error_q <= 1'b1;
         end
      end
   end

   assign busy  = busy_q;
   assign error = error_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// Multi-port integer register file with busy scoreboard, optional same-cycle
// write-to-read forwarding and issue hazard check (RAW on operands, WAW on rd).
// Register 0 reads as zero, ignores writes and is never busy.
module register_file_scoreboard
   import regfile_pkg::*;
#(
   parameter int REGISTER_COUNT = 32,
   parameter int WIDTH          = 32,
   parameter int READ_PORTS     = 2,
   parameter int WRITE_PORTS    = 1,
   parameter bit BYPASS         = 1'b1
)(
   input  logic                                                    clk,
   input  logic                                                    reset,
   input  logic [WRITE_PORTS-1:0]                                  WriteEnable,
   input  logic [WRITE_PORTS-1:0][addr_width(REGISTER_COUNT)-1:0]  WriteAdr,
   input  logic [WRITE_PORTS-1:0][WIDTH-1:0]                       WriteData,
   input  logic [READ_PORTS-1:0][addr_width(REGISTER_COUNT)-1:0]   ReadAdr,
   input  logic [READ_PORTS-1:0]                                   ReadUse,
   output logic [READ_PORTS-1:0][WIDTH-1:0]                        ReadData,
   output logic [READ_PORTS-1:0]                                   ReadReady,
   input  logic                                                    IssueValid,
   input  logic                                                    IssueWrites,
   input  logic [addr_width(REGISTER_COUNT)-1:0]                   IssueRd,
   output logic                                                    IssueAccept,
   output logic [REGISTER_COUNT-1:0]                               Busy,
   output logic                                                    Error
);

   localparam int AW = addr_width(REGISTER_COUNT);

   generate
      if (READ_PORTS < 1 || READ_PORTS > MAX_READ_PORTS ||
          WRITE_PORTS < 1 || WRITE_PORTS > MAX_WRITE_PORTS) begin : g_bad_ports
         $error("register_file_scoreboard: unsupported read/write port count");
      end
   endgenerate

   logic [WRITE_PORTS-1:0]                wr_en;
   logic [REGISTER_COUNT-1:0]             clearing;
   logic [REGISTER_COUNT-1:0][WIDTH-1:0]  wr_val;
   logic                                  collision;
   logic [REGISTER_COUNT-1:0][WIDTH-1:0]  regs;
   logic [REGISTER_COUNT-1:0]             busy;
   logic                                  error;
   logic                                  operands_ok;
   logic                                  dest_ok;
   logic                                  issue_set;

   // Qualify write strobes: r0 targets are dropped, and reset suppresses forwarding
   always_comb begin
      wr_en = '0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
         wr_en[p] = WriteEnable[p] && reset && (WriteAdr[p] != '0);
      end
   end

   // Per-register write decode; later ports override earlier ones on a shared target
   always_comb begin
      clearing = '0;
      wr_val   = '0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
         if (wr_en[p]) begin
            clearing[WriteAdr[p]] = 1'b1;
            wr_val[WriteAdr[p]]   = WriteData[p];
         end
      end
   end

   // Detect two qualified write ports naming the same register
   always_comb begin
      collision = 1'b0;
      for (int a = 0; a < WRITE_PORTS; a++) begin
         for (int b = a + 1; b < WRITE_PORTS; b++) begin
            if (wr_en[a] && wr_en[b] && (WriteAdr[a] == WriteAdr[b])) begin
               collision = 1'b1;
            end
         end
      end
   end

   // Register storage with per-register load enable; index 0 never loads and stays zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs <= '0;
      end else begin
         for (int i = 1; i < REGISTER_COUNT; i++) begin
            if (clearing[i]) begin
               regs[i] <= wr_val[i];
            end
         end
      end
   end

   // Read mux per port; with forwarding, a same-cycle write supplies both value and readiness
   always_comb begin
      ReadData  = '0;
      ReadReady = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         ReadData[r]  = regs[ReadAdr[r]];
         ReadReady[r] = !busy[ReadAdr[r]];
         if (BYPASS && clearing[ReadAdr[r]]) begin
            ReadData[r]  = wr_val[ReadAdr[r]];
            ReadReady[r] = 1'b1;
         end
      end
   end

   // Hazard check for the candidate instruction; deliberately independent of IssueValid
   always_comb begin
      operands_ok = &(ReadReady | ~ReadUse);
      dest_ok     = !IssueWrites || !busy[IssueRd] || clearing[IssueRd];
      IssueAccept = operands_ok && dest_ok;
   end

   assign issue_set = IssueValid && IssueAccept && IssueWrites && (IssueRd != '0);

   regfile_scoreboard #(
      .REGISTER_COUNT (REGISTER_COUNT)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .clearing  (clearing),
      .collision (collision),
      .issue_set (issue_set),
      .issue_rd  (IssueRd[AW-1:0]),
      .busy      (busy),
      .error     (error)
   );

   assign Busy  = busy;
   assign Error = error;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: a directed table (forwarding build) followed
// by random traffic, both builds (forwarding on/off) checked every cycle against
// a register/busy-set reference model.
module tb_register_file_scoreboard;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [1:0]           we;
   logic [1:0][4:0]      wa;
   logic [1:0][31:0]     wd;
   logic [3:0][4:0]      ra;
   logic [3:0]           ru;
   logic                 iv, iw;
   logic [4:0]           ird;
   logic [3:0][31:0]     rd_b, rd_n;
   logic [3:0]           rdy_b, rdy_n;
   logic                 acc_b, acc_n;
   logic [31:0]          busy_b, busy_n;
   logic                 err_b, err_n;

   always #5 clk = ~clk;

   register_file_scoreboard #(
      .REGISTER_COUNT(32), .WIDTH(32), .READ_PORTS(4), .WRITE_PORTS(2), .BYPASS(1'b1)
   ) dut (
      .clk(clk), .reset(rst_n), .WriteEnable(we), .WriteAdr(wa), .WriteData(wd),
      .ReadAdr(ra), .ReadUse(ru), .ReadData(rd_b), .ReadReady(rdy_b),
      .IssueValid(iv), .IssueWrites(iw), .IssueRd(ird), .IssueAccept(acc_b),
      .Busy(busy_b), .Error(err_b)
   );

   register_file_scoreboard #(
      .REGISTER_COUNT(32), .WIDTH(32), .READ_PORTS(4), .WRITE_PORTS(2), .BYPASS(1'b0)
   ) dut_nb (
      .clk(clk), .reset(rst_n), .WriteEnable(we), .WriteAdr(wa), .WriteData(wd),
      .ReadAdr(ra), .ReadUse(ru), .ReadData(rd_n), .ReadReady(rdy_n),
      .IssueValid(iv), .IssueWrites(iw), .IssueRd(ird), .IssueAccept(acc_n),
      .Busy(busy_n), .Error(err_n)
   );

   // Reference state: index 0 = no forwarding build, 1 = forwarding build
   logic [31:0] m_mem [32];
   logic [31:0] m_busy [2];
   logic        m_err [2];
   int          n_cmp = 0;
   int          n_miss = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      for (int b = 0; b < 2; b++) begin
         m_busy[b] = '0;
         m_err[b]  = 1'b0;
      end
   endtask

   // Compare both builds against the model for the current inputs, then advance the model
   task automatic model_step();
      logic [31:0] hit;
      logic [31:0] val [32];
      logic [31:0] e_rd;
      logic        e_rdy, e_acc, coll;
      logic [1:0]  acc;
      if (!rst_n) model_clear();
      hit = '0;
      for (int i = 0; i < 32; i++) val[i] = '0;
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if (we[p] && wa[p] != 0) begin
               hit[wa[p]] = 1'b1;
               val[wa[p]] = wd[p];
            end
         end
      end
      coll = rst_n && we[0] && we[1] && (wa[0] == wa[1]) && (wa[0] != 0);
      acc = '0;
      for (int b = 0; b < 2; b++) begin
         e_acc = 1'b1;
         for (int r = 0; r < 4; r++) begin
            e_rd  = m_mem[ra[r]];
            e_rdy = !m_busy[b][ra[r]];
            if (b == 1 && hit[ra[r]]) begin
               e_rd  = val[ra[r]];
               e_rdy = 1'b1;
            end
            if (ru[r] && !e_rdy) e_acc = 1'b0;
            chk($sformatf("%s ReadData[%0d]", b ? "byp" : "nobyp", r), b ? rd_b[r] : rd_n[r], e_rd);
            chk($sformatf("%s ReadReady[%0d]", b ? "byp" : "nobyp", r),
                {31'd0, b ? rdy_b[r] : rdy_n[r]}, {31'd0, e_rdy});
         end
         if (iw && m_busy[b][ird] && !hit[ird]) e_acc = 1'b0;
         chk($sformatf("%s IssueAccept", b ? "byp" : "nobyp"), {31'd0, b ? acc_b : acc_n}, {31'd0, e_acc});
         chk($sformatf("%s Busy", b ? "byp" : "nobyp"), b ? busy_b : busy_n, m_busy[b]);
         chk($sformatf("%s Error", b ? "byp" : "nobyp"), {31'd0, b ? err_b : err_n}, {31'd0, m_err[b]});
         acc[b] = e_acc;
      end
      if (rst_n) begin
         for (int b = 0; b < 2; b++) begin
            if (coll || ((hit & ~m_busy[b]) != 0)) m_err[b] = 1'b1;
            m_busy[b] = m_busy[b] & ~hit;
            if (iv && acc[b] && iw && ird != 0) m_busy[b][ird] = 1'b1;
         end
         for (int i = 1; i < 32; i++) if (hit[i]) m_mem[i] = val[i];
      end
   endtask

   function automatic logic [4:0] pick_wr_addr();
      int start;
      if ($urandom_range(0, 3) != 0 && m_busy[1] != 0) begin
         start = $urandom_range(0, 31);
         for (int k = 0; k < 32; k++) begin
            if (m_busy[1][(start + k) % 32]) return 5'((start + k) % 32);
         end
      end
      return 5'($urandom_range(0, 15));
   endfunction

   typedef struct {
      logic        rst;
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra;
      logic        ru;
      logic        iv, iw;
      logic [4:0]  ird;
      logic [31:0] e_rd;
      logic        e_rdy, e_acc, e_bsy, e_err;
   } vec_t;

   function automatic vec_t mk(logic rst, logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
                               logic [4:0] a1, logic [31:0] d1, logic [4:0] rda, logic use_,
                               logic v, logic wr, logic [4:0] rdst, logic [31:0] x_rd,
                               logic x_rdy, logic x_acc, logic x_bsy, logic x_err);
      vec_t t;
      t.rst = rst; t.we = w; t.wa0 = a0; t.wd0 = d0; t.wa1 = a1; t.wd1 = d1;
      t.ra = rda; t.ru = use_; t.iv = v; t.iw = wr; t.ird = rdst;
      t.e_rd = x_rd; t.e_rdy = x_rdy; t.e_acc = x_acc; t.e_bsy = x_bsy; t.e_err = x_err;
      return t;
   endfunction

   vec_t tv [24];

   initial begin
      //           rst we  wa0 wd0           wa1 wd1    ra ru iv iw ird  e_rd          rdy acc bsy err
      tv[0]  = mk(0, 2'b00, 0, 0,             0, 0,     0, 0, 0, 0, 0,  0,             1, 1, 0, 0);
      tv[1]  = mk(1, 2'b00, 0, 0,             0, 0,     5, 0, 1, 1, 5,  0,             1, 1, 0, 0);
      tv[2]  = mk(1, 2'b01, 5, 32'hDEADBEEF,  0, 0,     5, 1, 0, 0, 0,  32'hDEADBEEF,  1, 1, 1, 0);
      tv[3]  = mk(1, 2'b00, 0, 0,             0, 0,     5, 0, 1, 1, 5,  32'hDEADBEEF,  1, 1, 0, 0);
      tv[4]  = mk(1, 2'b00, 0, 0,             0, 0,     5, 1, 0, 0, 0,  32'hDEADBEEF,  0, 0, 1, 0);
      tv[5]  = mk(0, 2'b00, 0, 0,             0, 0,     5, 1, 0, 0, 0,  0,             1, 1, 0, 0);
      tv[6]  = mk(1, 2'b00, 0, 0,             0, 0,     3, 0, 1, 1, 3,  0,             1, 1, 0, 0);
      tv[7]  = mk(1, 2'b00, 0, 0,             0, 0,     3, 1, 1, 0, 0,  0,             0, 0, 1, 0);
      tv[8]  = mk(1, 2'b00, 0, 0,             0, 0,     3, 1, 1, 0, 0,  0,             0, 0, 1, 0);
      tv[9]  = mk(1, 2'b00, 0, 0,             0, 0,     3, 1, 1, 0, 0,  0,             0, 0, 1, 0);
      tv[10] = mk(1, 2'b01, 3, 32'h1234,      0, 0,     3, 1, 1, 0, 0,  32'h1234,      1, 1, 1, 0);
      tv[11] = mk(1, 2'b00, 0, 0,             0, 0,     3, 1, 0, 0, 0,  32'h1234,      1, 1, 0, 0);
      tv[12] = mk(1, 2'b01, 0, 32'hFFFF,      0, 0,     0, 1, 0, 0, 0,  0,             1, 1, 0, 0);
      tv[13] = mk(1, 2'b00, 0, 0,             0, 0,     0, 1, 0, 0, 0,  0,             1, 1, 0, 0);
      tv[14] = mk(1, 2'b00, 0, 0,             0, 0,     9, 0, 1, 1, 9,  0,             1, 1, 0, 0);
      tv[15] = mk(1, 2'b10, 0, 0,             9, 32'h99, 9, 0, 1, 1, 9, 32'h99,        1, 1, 1, 0);
      tv[16] = mk(1, 2'b00, 0, 0,             0, 0,     9, 1, 0, 0, 0,  32'h99,        0, 0, 1, 0);
      tv[17] = mk(1, 2'b00, 0, 0,             0, 0,     7, 0, 1, 1, 7,  0,             1, 1, 0, 0);
      tv[18] = mk(1, 2'b11, 7, 32'hAA,        7, 32'hBB, 7, 0, 0, 0, 0, 32'hBB,        1, 1, 1, 0);
      tv[19] = mk(1, 2'b00, 0, 0,             0, 0,     7, 1, 0, 0, 0,  32'hBB,        1, 1, 0, 1);
      tv[20] = mk(1, 2'b00, 0, 0,             0, 0,     7, 1, 0, 0, 0,  32'hBB,        1, 1, 0, 1);
      tv[21] = mk(0, 2'b00, 0, 0,             0, 0,     7, 1, 0, 0, 0,  0,             1, 1, 0, 0);
      tv[22] = mk(1, 2'b01, 4, 32'h44,        0, 0,     4, 1, 0, 0, 0,  32'h44,        1, 1, 0, 0);
      tv[23] = mk(1, 2'b00, 0, 0,             0, 0,     4, 1, 0, 0, 0,  32'h44,        1, 1, 0, 1);

      model_clear();

      for (int i = 0; i < 24; i++) begin
         rst_n = tv[i].rst;
         we    = tv[i].we;
         wa[0] = tv[i].wa0;  wd[0] = tv[i].wd0;
         wa[1] = tv[i].wa1;  wd[1] = tv[i].wd1;
         for (int r = 0; r < 4; r++) ra[r] = tv[i].ra;
         ru    = {4{tv[i].ru}};
         iv    = tv[i].iv;  iw = tv[i].iw;  ird = tv[i].ird;
         @(negedge clk);
         for (int r = 0; r < 4; r++) chk($sformatf("row%0d ReadData[%0d]", i, r), rd_b[r], tv[i].e_rd);
         chk($sformatf("row%0d ReadReady", i), {31'd0, rdy_b[0]}, {31'd0, tv[i].e_rdy});
         chk($sformatf("row%0d IssueAccept", i), {31'd0, acc_b}, {31'd0, tv[i].e_acc});
         chk($sformatf("row%0d Busy[ra]", i), {31'd0, busy_b[tv[i].ra]}, {31'd0, tv[i].e_bsy});
         chk($sformatf("row%0d Busy[0]", i), {31'd0, busy_b[0]}, 32'd0);
         chk($sformatf("row%0d Error", i), {31'd0, err_b}, {31'd0, tv[i].e_err});
         // Without forwarding the cycle-4 writeback becomes visible one cycle later
         if (i == 10) begin
            chk("nobyp wb-cycle ReadReady", {31'd0, rdy_n[0]}, 32'd0);
            chk("nobyp wb-cycle IssueAccept", {31'd0, acc_n}, 32'd0);
            chk("nobyp wb-cycle ReadData", rd_n[0], 32'd0);
         end
         if (i == 11) begin
            chk("nobyp next-cycle ReadReady", {31'd0, rdy_n[0]}, 32'd1);
            chk("nobyp next-cycle IssueAccept", {31'd0, acc_n}, 32'd1);
            chk("nobyp next-cycle ReadData", rd_n[0], 32'h1234);
         end
         model_step();
         @(posedge clk);
         #1;
      end

      for (int c = 0; c < 2000; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int p = 0; p < 2; p++) begin
            we[p] = 1'($urandom_range(0, 1));
            wa[p] = pick_wr_addr();
            wd[p] = $urandom;
         end
         for (int r = 0; r < 4; r++) begin
            ra[r] = 5'($urandom_range(0, 15));
            ru[r] = 1'($urandom_range(0, 1));
         end
         iv  = 1'($urandom_range(0, 1));
         iw  = 1'($urandom_range(0, 1));
         ird = 5'($urandom_range(0, 15));
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
